// File: rtl/iob_eth_rx_dma_pkg.sv
// Shared constants for the Ethernet RX DMA: core register map, status bits,
// controller state encoding and the data-buffer address helper.
package iob_eth_rx_dma_pkg;

  localparam logic [11:0] ETH_STATUS   = 12'h001;
  localparam logic [11:0] ETH_RCVACK   = 12'h002;
  localparam int          ETH_DATA_BIT = 11;
  localparam int          RX_RCVD_BIT  = 1;
  localparam int          CNT_W        = 11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_POLL_WAIT,
    S_RD,
    S_PUSH,
    S_ACK,
    S_DONE
  } rx_state_t;

  // RX buffer byte k lives at {1'b1, k}
  function automatic logic [11:0] eth_data_addr(input logic [CNT_W-1:0] k);
    logic [11:0] a;
    a               = '0;
    a[CNT_W-1:0]    = k;
    a[ETH_DATA_BIT] = 1'b1;
    return a;
  endfunction

endpackage

// File: rtl/iob_eth_bus_master.sv
// Single-outstanding access sequencer for the Ethernet core port.
// Holds sel/addr/we/wdata from issue until ready, ignores ready in the issue
// cycle, and guarantees a sel-low gap (the ack cycle) between accesses.
module iob_eth_bus_master #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              eth_sel,
  output logic              eth_we,
  output logic [ADDR_W-1:0] eth_addr,
  output logic [31:0]       eth_wdata,
  input  logic [31:0]       eth_rdata,
  input  logic              eth_ready
);

  logic issue_cyc;

  // Issue on req when the bus is free; complete on ready after the issue cycle.
  // A new request is blocked during the ack cycle so sel stays low for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eth_sel   <= 1'b0;
      eth_we    <= 1'b0;
      eth_addr  <= '0;
      eth_wdata <= '0;
      issue_cyc <= 1'b0;
      ack       <= 1'b0;
      rdata     <= '0;
    end else begin
      ack <= 1'b0;
      if (eth_sel) begin
        issue_cyc <= 1'b0;
        if (!issue_cyc && eth_ready) begin
          eth_sel <= 1'b0;
          eth_we  <= 1'b0;
          ack     <= 1'b1;
          rdata   <= eth_rdata;
        end
      end else if (req && !ack) begin
        eth_sel   <= 1'b1;
        eth_we    <= req_we;
        eth_addr  <= req_addr;
        eth_wdata <= req_wdata;
        issue_cyc <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_eth_rx_dma.sv
// Ethernet RX DMA: polls the core for a received frame, reads it byte by
// byte, packs little-endian 32-bit words onto a valid/ready stream, then
// acknowledges the frame to the core with an RCVACK write.
module iob_eth_rx_dma
  import iob_eth_rx_dma_pkg::*;
#(
  parameter int ETH_ADDR_W = 12,
  parameter int POLL_DLY   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [10:0]           nbytes,
  output logic                  busy,
  output logic                  done,
  output logic                  eth_sel,
  output logic                  eth_we,
  output logic [ETH_ADDR_W-1:0] eth_addr,
  output logic [31:0]           eth_wdata,
  input  logic [31:0]           eth_rdata,
  input  logic                  eth_ready,
  output logic                  m_valid,
  output logic [31:0]           m_data,
  output logic [3:0]            m_strb,
  output logic                  m_last,
  input  logic                  m_ready
);

  rx_state_t             state, state_n;
  logic [CNT_W-1:0]      nbytes_q;
  logic [CNT_W-1:0]      k;
  logic [15:0]           wait_cnt;
  logic                  req, req_we;
  logic [ETH_ADDR_W-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  bm_ack;
  logic [31:0]           bm_rdata;
  logic                  last_byte;
  logic                  unused_rdata;

  assign last_byte    = (k == nbytes_q - 11'd1);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign m_valid      = (state == S_PUSH);
  assign unused_rdata = ^bm_rdata[31:8];

  iob_eth_bus_master #(.ADDR_W(ETH_ADDR_W)) u_bm (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (bm_ack),
    .rdata     (bm_rdata),
    .eth_sel   (eth_sel),
    .eth_we    (eth_we),
    .eth_addr  (eth_addr),
    .eth_wdata (eth_wdata),
    .eth_rdata (eth_rdata),
    .eth_ready (eth_ready)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next state and core access requests
  always_comb begin
    state_n   = state;
    req       = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    case (state)
      S_IDLE: if (start) state_n = S_POLL;
      S_POLL: begin
        req      = 1'b1;
        req_addr = ETH_ADDR_W'(ETH_STATUS);
        if (bm_ack) begin
          if (bm_rdata[RX_RCVD_BIT]) state_n = (nbytes_q == '0) ? S_ACK : S_RD;
          else                       state_n = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: if (wait_cnt == 16'(POLL_DLY - 1)) state_n = S_POLL;
      S_RD: begin
        req      = 1'b1;
        req_addr = ETH_ADDR_W'(eth_data_addr(k));
        if (bm_ack && (k[1:0] == 2'd3 || last_byte)) state_n = S_PUSH;
      end
      // m_last doubles as "no bytes remain" for the word being pushed
      S_PUSH: if (m_ready) state_n = m_last ? S_ACK : S_RD;
      S_ACK: begin
        req       = 1'b1;
        req_we    = 1'b1;
        req_addr  = ETH_ADDR_W'(ETH_RCVACK);
        req_wdata = 32'd1;
        if (bm_ack) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Frame length, byte counter, poll delay counter and word packing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nbytes_q <= '0;
      k        <= '0;
      wait_cnt <= '0;
      m_data   <= '0;
      m_strb   <= '0;
      m_last   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          nbytes_q <= nbytes;
          k        <= '0;
          m_data   <= '0;
          m_strb   <= '0;
          m_last   <= 1'b0;
        end
        S_POLL:      wait_cnt <= '0;
        S_POLL_WAIT: wait_cnt <= wait_cnt + 16'd1;
        S_RD: if (bm_ack) begin
          m_data[{k[1:0], 3'b000} +: 8] <= bm_rdata[7:0];
          m_strb[k[1:0]]                <= 1'b1;
          m_last                        <= last_byte;
          k                             <= k + 11'd1;
        end
        // Start the next word from a clean slate so unused lanes stay zero
        S_PUSH: if (m_ready) begin
          m_data <= '0;
          m_strb <= '0;
          m_last <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_eth_rx_dma.sv
// Directed bench for iob_eth_rx_dma: core responder, stream/access logging,
// hand-computed expectations per scenario.
module tb_iob_eth_rx_dma;
  import iob_eth_rx_dma_pkg::*;

  localparam int AW = 12;
  localparam int PD = 16;

  logic          clk, rst_n, start;
  logic [10:0]   nbytes;
  logic          busy, done, eth_sel, eth_we, eth_ready;
  logic [AW-1:0] eth_addr;
  logic [31:0]   eth_wdata, eth_rdata, m_data;
  logic          m_valid, m_last, m_ready;
  logic [3:0]    m_strb;

  iob_eth_rx_dma #(.ETH_ADDR_W(AW), .POLL_DLY(PD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nbytes(nbytes),
    .busy(busy), .done(done),
    .eth_sel(eth_sel), .eth_we(eth_we), .eth_addr(eth_addr),
    .eth_wdata(eth_wdata), .eth_rdata(eth_rdata), .eth_ready(eth_ready),
    .m_valid(m_valid), .m_data(m_data), .m_strb(m_strb), .m_last(m_last),
    .m_ready(m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          rise;
    int          fall;
  } acc_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } word_t;

  acc_t  acc_q[$];
  word_t wq[$];
  logic [7:0] mem [0:2047];

  int n_tests = 0, n_fail = 0;
  int zero_polls = 0, polls_seen = 0, done_cnt = 0;
  int stab_err = 0, hold_err = 0, sel_in_push = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Core responder and monitors, all evaluated at the falling edge
  initial begin
    logic        sel_prev, mv_prev, mr_prev, ml_prev;
    logic [31:0] md_prev;
    logic [3:0]  ms_prev;
    acc_t        cap;
    word_t       w;
    sel_prev = 0; mv_prev = 0; mr_prev = 0; ml_prev = 0; md_prev = 0; ms_prev = 0;
    cap = '{default: 0};
    eth_ready = 0; eth_rdata = 0;
    forever begin
      @(negedge clk);
      if (eth_sel && !sel_prev) begin
        cap.addr = eth_addr; cap.we = eth_we; cap.wdata = eth_wdata; cap.rise = cyc;
        if (eth_addr == ETH_STATUS) begin
          eth_rdata = (polls_seen >= zero_polls) ? 32'h2 : 32'h0;
          polls_seen++;
        end else begin
          eth_rdata = {24'h5A5A5A, mem[eth_addr[10:0]]};
        end
        eth_ready = 0;
      end else if (eth_sel && sel_prev) begin
        if (eth_addr != cap.addr || eth_we != cap.we || eth_wdata != cap.wdata) stab_err++;
        eth_ready = 1;
      end else if (!eth_sel && sel_prev) begin
        cap.fall = cyc;
        acc_q.push_back(cap);
        eth_ready = 0;
      end else begin
        eth_ready = 0;
      end
      sel_prev = eth_sel;
      if (eth_sel && m_valid) sel_in_push++;
      if (mv_prev && !mr_prev && rst_n)
        if (!m_valid || m_data != md_prev || m_strb != ms_prev || m_last != ml_prev) hold_err++;
      if (m_valid && m_ready) begin
        w.data = m_data; w.strb = m_strb; w.last = m_last;
        wq.push_back(w);
      end
      mv_prev = m_valid; mr_prev = m_ready; md_prev = m_data; ms_prev = m_strb; ml_prev = m_last;
      if (done) done_cnt++;
    end
  end

  task automatic clear_logs();
    acc_q.delete(); wq.delete();
    polls_seen = 0; done_cnt = 0;
  endtask

  function automatic int cnt_addr(input logic [11:0] a, input logic we);
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i].addr == a && acc_q[i].we == we) n++;
    return n;
  endfunction

  function automatic int cnt_data();
    int n = 0;
    foreach (acc_q[i]) if (acc_q[i].addr[11]) n++;
    return n;
  endfunction

  task automatic pulse_start(input logic [10:0] n);
    @(posedge clk); #1;
    start = 1; nbytes = n;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int c = 0;
    while (done_cnt == 0 && c < bound) begin
      @(posedge clk); c++;
    end
    chk(tag, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input int i, input logic [31:0] d,
                          input logic [3:0] s, input logic l);
    if (wq.size() > i) begin
      chk({tag, "_data"}, wq[i].data, d);
      chk({tag, "_strb"}, 32'(wq[i].strb), 32'(s));
      chk({tag, "_last"}, 32'(wq[i].last), 32'(l));
    end else begin
      chk({tag, "_missing"}, 32'(wq.size()), 32'(i + 1));
    end
  endtask

  initial begin
    int c, min_gap, last_stat_fall, first_data_rise;
    rst_n = 0; start = 0; nbytes = 0; m_ready = 1;
    foreach (mem[i]) mem[i] = 8'hEE;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sel_we", {30'd0, eth_sel, eth_we}, 0);
    chk("rst_addr", 32'(eth_addr), 0);
    chk("rst_wdata", eth_wdata, 0);
    chk("rst_stream", {m_valid, m_last, m_strb, 26'd0} | m_data, 0);
    rst_n = 1;
    repeat (2) @(posedge clk); #1;

    // 8-byte frame, ready on first poll
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    clear_logs(); zero_polls = 0;
    pulse_start(11'd8);
    chk("a_busy", 32'(busy), 1);
    wait_done("a_done", 2000);
    chk("a_nwords", 32'(wq.size()), 2);
    chk_word("a_w0", 0, 32'h04030201, 4'hF, 1'b0);
    chk_word("a_w1", 1, 32'h08070605, 4'hF, 1'b1);
    chk("a_nreads", 32'(cnt_data()), 8);
    if (acc_q.size() > 1) begin
      chk("a_addr0", 32'(acc_q[1].addr), 32'h800);
      chk("a_addr7", 32'(acc_q[acc_q.size() - 2].addr), 32'h807);
    end else chk("a_accesses", 32'(acc_q.size()), 10);
    chk("a_polls", 32'(cnt_addr(ETH_STATUS, 1'b0)), 1);
    chk("a_rcvack", 32'(cnt_addr(ETH_RCVACK, 1'b1)), 1);
    if (acc_q.size() > 0) begin
      chk("a_ack_addr", 32'(acc_q[acc_q.size() - 1].addr), 32'(ETH_RCVACK));
      chk("a_ack_wdata", acc_q[acc_q.size() - 1].wdata, 1);
    end
    chk("a_idle", 32'(busy), 0);

    // 5-byte frame, partial final word
    for (int i = 0; i < 5; i++) mem[i] = 8'hA0 + 8'(i);
    clear_logs();
    pulse_start(11'd5);
    wait_done("b_done", 2000);
    chk("b_nwords", 32'(wq.size()), 2);
    chk_word("b_w0", 0, 32'hA3A2A1A0, 4'hF, 1'b0);
    chk_word("b_w1", 1, 32'h000000A4, 4'h1, 1'b1);

    // Three empty polls before data
    for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
    clear_logs(); zero_polls = 3;
    pulse_start(11'd4);
    wait_done("c_done", 2000);
    chk("c_polls", 32'(cnt_addr(ETH_STATUS, 1'b0)), 4);
    min_gap = 1 << 20; last_stat_fall = -1; first_data_rise = -1;
    foreach (acc_q[i]) begin
      if (acc_q[i].addr == ETH_STATUS) begin
        if (last_stat_fall >= 0 && acc_q[i].rise - last_stat_fall < min_gap)
          min_gap = acc_q[i].rise - last_stat_fall;
        last_stat_fall = acc_q[i].fall;
      end
      if (acc_q[i].addr[11] && first_data_rise < 0) first_data_rise = acc_q[i].rise;
    end
    chk("c_poll_gap", 32'(min_gap >= PD), 1);
    chk("c_no_early_rd", 32'(first_data_rise > last_stat_fall), 1);
    chk_word("c_w0", 0, 32'h13121110, 4'hF, 1'b1);
    zero_polls = 0;

    // Backpressure on the first word
    for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
    clear_logs(); hold_err = 0; sel_in_push = 0;
    m_ready = 0;
    pulse_start(11'd8);
    c = 0;
    while (!m_valid && c < 500) begin @(posedge clk); #1; c++; end
    chk("d_valid_seen", 32'(m_valid), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("d_valid_held", 32'(m_valid), 1);
    chk("d_data_held", m_data, 32'h04030201);
    m_ready = 1;
    wait_done("d_done", 2000);
    chk("d_hold_err", 32'(hold_err), 0);
    chk("d_sel_in_push", 32'(sel_in_push), 0);
    chk("d_nwords", 32'(wq.size()), 2);
    chk_word("d_w1", 1, 32'h08070605, 4'hF, 1'b1);

    // Zero-length frame, extra start while busy
    clear_logs();
    pulse_start(11'd0);
    pulse_start(11'd3);
    wait_done("e_done", 2000);
    repeat (60) @(posedge clk);
    #1;
    chk("e_nwords", 32'(wq.size()), 0);
    chk("e_nreads", 32'(cnt_data()), 0);
    chk("e_rcvack", 32'(cnt_addr(ETH_RCVACK, 1'b1)), 1);
    chk("e_polls", 32'(cnt_addr(ETH_STATUS, 1'b0)), 1);
    chk("e_done_once", 32'(done_cnt), 1);
    chk("e_idle", 32'(busy), 0);

    // Reset during a data read of a 64-byte frame
    for (int i = 0; i < 64; i++) mem[i] = 8'hC0 + 8'(i);
    clear_logs();
    pulse_start(11'd64);
    c = 0;
    while (!(cnt_data() >= 6 && eth_sel && eth_addr[11]) && c < 2000) begin
      @(posedge clk); #1; c++;
    end
    chk("f_in_rd", 32'(eth_sel && eth_addr[11]), 1);
    rst_n = 0;
    #1;
    chk("f_rst_busy_done", {30'd0, busy, done}, 0);
    chk("f_rst_sel_we", {30'd0, eth_sel, eth_we}, 0);
    chk("f_rst_addr", 32'(eth_addr), 0);
    chk("f_rst_wdata", eth_wdata, 0);
    chk("f_rst_mvl", {30'd0, m_valid, m_last}, 0);
    chk("f_rst_mdata", m_data, 0);
    chk("f_rst_mstrb", 32'(m_strb), 0);
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst_n = 1;
    repeat (80) @(posedge clk);
    #1;
    chk("f_no_rcvack", 32'(cnt_addr(ETH_RCVACK, 1'b1)), 0);
    chk("f_no_access", 32'(acc_q.size()), 0);
    chk("f_no_words", 32'(wq.size()), 0);
    chk("f_no_done", 32'(done_cnt), 0);

    // Recovery frame after reset
    for (int i = 0; i < 5; i++) mem[i] = 8'hA0 + 8'(i);
    clear_logs();
    pulse_start(11'd5);
    wait_done("g_done", 2000);
    chk_word("g_w0", 0, 32'hA3A2A1A0, 4'hF, 1'b0);
    chk_word("g_w1", 1, 32'h000000A4, 4'h1, 1'b1);

    chk("bus_stable", 32'(stab_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
